aes_out_axis_tx: RTL and testbench

Output stage downstream of the AES controller. It accepts 128-bit result blocks on a simple write strobe and stores them in a circular block-RAM FIFO. It serializes each block into four 32-bit words on an AXI4-Stream master and asserts tlast on the final word of a request. It replaces the flat output word array and the read-pointer logic in the AXI stream wrapper's master side.

---
 rtl/aes_out_axis_tx.sv | 266 ++++++++++++++++++++++++++
 tb/tb_aes_out_axis_tx.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_out_axis_tx.sv
// ============================================================================
// Module   : aes_out_axis_tx
// Purpose  : AES result output stage. Buffers 128-bit result blocks in a
//            circular block-RAM FIFO and serializes each block into four
//            32-bit words on an AXI4-Stream master, most significant word
//            first. tlast marks the final word of a request.
// Ports    : clk, reset (async, active-high)
//            in_w_e / in_data / in_last    block write strobe, data, last flag
//            in_full / in_blk_cnt          FIFO occupancy
//            overflow                      sticky write-while-full flag
//            m_axis_t*                     AXI4-Stream master
//            tx_done                       pulse after the tlast handshake
// Options  : AES_OUT_BYTESWAP_EN - byte-reverse every outgoing word
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_out_axis_tx #(
    parameter int ADDR_WIDTH = 9,
    parameter int DEPTH      = 512,
    parameter int WORD_S     = 32,
    parameter int DATA_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_w_e,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic                  in_full,
    output logic [ADDR_WIDTH:0]   in_blk_cnt,
    output logic                  overflow,
    output logic                  m_axis_tvalid,
    output logic [WORD_S-1:0]     m_axis_tdata,
    output logic [WORD_S/8-1:0]   m_axis_tstrb,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic                  tx_done
);

    localparam int                c_CNT_W     = ADDR_WIDTH + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_SEND  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_CNT_W-1:0]    cnt_q, cnt_d;
    // Blocks written but not yet read out of the RAM (excludes blocks
    // already in flight, in the prefetch register or in the shifter).
    logic [c_CNT_W-1:0]    unrd_q, unrd_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic                  last_q, last_d;
    logic [1:0]            idx_q, idx_d;
    logic [DATA_WIDTH-1:0] pf_data_q, pf_data_d;
    logic                  pf_last_q, pf_last_d;
    logic                  pf_valid_q, pf_valid_d;
    logic                  pf_pend_q, pf_pend_d;
    logic                  tvalid_q, tvalid_d;
    logic                  done_q, done_d;
    logic                  ovf_q, ovf_d;

    logic                  w_full;
    logic                  w_wr_acc;
    logic                  w_rd_en;
    logic                  w_hs;
    logic                  w_blk_done;
    logic                  w_unrd_nz;
    logic                  w_tlast;
    logic [WORD_S-1:0]     w_word;

    // ------------------------------------------------------------------
    // Block RAM: {last, data}, synchronous write, registered read.
    // ------------------------------------------------------------------
    logic [DATA_WIDTH:0]   mem [DEPTH];
    logic [DATA_WIDTH:0]   ram_rd_q;

    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            mem[wr_ptr_q] <= {in_last, in_data};
        end
        if (w_rd_en) begin
            ram_rd_q <= mem[rd_ptr_q];
        end
    end

    assign w_full     = (cnt_q == c_DEPTH_CNT);
    assign w_wr_acc   = in_w_e && !w_full;
    assign w_hs       = tvalid_q && m_axis_tready;
    assign w_unrd_nz  = (unrd_q != '0);
    assign w_tlast    = tvalid_q && (idx_q == 2'd3) && last_q;

    // ------------------------------------------------------------------
    // Read FSM and datapath next-state
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        rd_ptr_d   = rd_ptr_q;
        shreg_d    = shreg_q;
        last_d     = last_q;
        idx_d      = idx_q;
        pf_data_d  = pf_data_q;
        pf_last_d  = pf_last_q;
        pf_valid_d = pf_valid_q;
        pf_pend_d  = pf_pend_q;
        tvalid_d   = tvalid_q;
        w_rd_en    = 1'b0;
        w_blk_done = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (w_unrd_nz) begin
                    w_rd_en = 1'b1;
                    state_d = S_FETCH;
                end
            end

            S_FETCH: begin
                shreg_d  = ram_rd_q[DATA_WIDTH-1:0];
                last_d   = ram_rd_q[DATA_WIDTH];
                idx_d    = 2'd0;
                tvalid_d = 1'b1;
                state_d  = S_SEND;
            end

            S_SEND: begin
                // A prefetch read issued last cycle lands in the prefetch
                // register, unless this cycle ends the block: then the RAM
                // output is consumed directly by FETCH instead.
                if (pf_pend_q && !(w_hs && idx_q == 2'd3)) begin
                    pf_data_d  = ram_rd_q[DATA_WIDTH-1:0];
                    pf_last_d  = ram_rd_q[DATA_WIDTH];
                    pf_valid_d = 1'b1;
                    pf_pend_d  = 1'b0;
                end

                if (idx_q != 2'd3 && !pf_valid_q && !pf_pend_q && w_unrd_nz) begin
                    w_rd_en   = 1'b1;
                    pf_pend_d = 1'b1;
                end

                if (w_hs) begin
                    if (idx_q != 2'd3) begin
                        shreg_d = shreg_q << WORD_S;
                        idx_d   = idx_q + 2'd1;
                    end else begin
                        w_blk_done = 1'b1;
                        idx_d      = 2'd0;
                        if (pf_valid_q) begin
                            shreg_d    = pf_data_q;
                            last_d     = pf_last_q;
                            pf_valid_d = 1'b0;
                        end else if (pf_pend_q) begin
                            pf_pend_d = 1'b0;
                            tvalid_d  = 1'b0;
                            state_d   = S_FETCH;
                        end else if (w_unrd_nz) begin
                            w_rd_en  = 1'b1;
                            tvalid_d = 1'b0;
                            state_d  = S_FETCH;
                        end else begin
                            tvalid_d = 1'b0;
                            state_d  = S_IDLE;
                        end
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (w_rd_en) begin
            rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
        end
    end

    // ------------------------------------------------------------------
    // Pointers, counters and status next-state
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = w_wr_acc ? (wr_ptr_q + ADDR_WIDTH'(1)) : wr_ptr_q;

        unrd_d = unrd_q;
        case ({w_wr_acc, w_rd_en})
            2'b10:   unrd_d = unrd_q + c_CNT_W'(1);
            2'b01:   unrd_d = unrd_q - c_CNT_W'(1);
            default: unrd_d = unrd_q;
        endcase

        cnt_d = cnt_q;
        case ({w_wr_acc, w_blk_done})
            2'b10:   cnt_d = cnt_q + c_CNT_W'(1);
            2'b01:   cnt_d = cnt_q - c_CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase

        ovf_d  = ovf_q || (in_w_e && w_full);
        done_d = w_hs && w_tlast;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            unrd_q     <= '0;
            shreg_q    <= '0;
            last_q     <= 1'b0;
            idx_q      <= 2'd0;
            pf_data_q  <= '0;
            pf_last_q  <= 1'b0;
            pf_valid_q <= 1'b0;
            pf_pend_q  <= 1'b0;
            tvalid_q   <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            unrd_q     <= unrd_d;
            shreg_q    <= shreg_d;
            last_q     <= last_d;
            idx_q      <= idx_d;
            pf_data_q  <= pf_data_d;
            pf_last_q  <= pf_last_d;
            pf_valid_q <= pf_valid_d;
            pf_pend_q  <= pf_pend_d;
            tvalid_q   <= tvalid_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign w_word = shreg_q[DATA_WIDTH-1 -: WORD_S];

`ifdef AES_OUT_BYTESWAP_EN
    for (genvar b = 0; b < WORD_S/8; b++) begin : g_bswap
        assign m_axis_tdata[8*b +: 8] = w_word[WORD_S-8-8*b +: 8];
    end
`else
    assign m_axis_tdata = w_word;
`endif

    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = w_tlast;
    assign m_axis_tstrb  = '1;
    assign in_full       = w_full;
    assign in_blk_cnt    = cnt_q;
    assign overflow      = ovf_q;
    assign tx_done       = done_q;

endmodule

`default_nettype wire

// File: tb/tb_aes_out_axis_tx.sv
// ============================================================================
// Module   : tb_aes_out_axis_tx
// Purpose  : Self-checking bench for aes_out_axis_tx. A queue-based model of
//            the expected word stream and FIFO occupancy is checked against
//            the DUT every cycle; directed scenarios pin exact timing and
//            literal values.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_aes_out_axis_tx;

    localparam int AW    = 9;
    localparam int DEPTH = 512;
    localparam int WS    = 32;
    localparam int DW    = 128;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_w_e = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_last = 1'b0;
    logic          tready = 1'b0;
    logic          in_full;
    logic [AW:0]   in_blk_cnt;
    logic          overflow;
    logic          tvalid;
    logic [WS-1:0] tdata;
    logic [WS/8-1:0] tstrb;
    logic          tlast;
    logic          tx_done;

    always #5 clk = ~clk;

    aes_out_axis_tx #(
        .ADDR_WIDTH (AW),
        .DEPTH      (DEPTH),
        .WORD_S     (WS),
        .DATA_WIDTH (DW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .in_w_e        (in_w_e),
        .in_data       (in_data),
        .in_last       (in_last),
        .in_full       (in_full),
        .in_blk_cnt    (in_blk_cnt),
        .overflow      (overflow),
        .m_axis_tvalid (tvalid),
        .m_axis_tdata  (tdata),
        .m_axis_tstrb  (tstrb),
        .m_axis_tlast  (tlast),
        .m_axis_tready (tready),
        .tx_done       (tx_done)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] sw(input logic [31:0] w);
`ifdef AES_OUT_BYTESWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    // ------------------------------------------------------------------
    // Reference model: expected word stream and block occupancy
    // ------------------------------------------------------------------
    typedef struct {
        logic [31:0] d;
        logic        last;
        logic        eob;
    } ent_t;

    ent_t        q[$];
    int          m_cnt = 0;
    logic        m_ovf = 1'b0;
    logic        m_done = 1'b0;
    int          hs_total = 0;
    logic        stall_prev = 1'b0;
    logic [31:0] prev_data = '0;

    task automatic push_blk(input logic [127:0] b, input logic l);
        ent_t e;
        for (int i = 0; i < 4; i++) begin
            e.d    = sw(b[127-32*i -: 32]);
            e.last = l && (i == 3);
            e.eob  = (i == 3);
            q.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            q.delete();
            m_cnt      = 0;
            m_ovf      = 1'b0;
            m_done     = 1'b0;
            stall_prev = 1'b0;
        end else begin
            logic acc;
            ent_t e;
            chk("blk_cnt", 64'(in_blk_cnt), 64'(m_cnt));
            chk("in_full", 64'(in_full), 64'(m_cnt == DEPTH));
            chk("overflow", 64'(overflow), 64'(m_ovf));
            chk("tx_done", 64'(tx_done), 64'(m_done));
            chk("tstrb", 64'(tstrb), 64'hF);
            if (tvalid) begin
                if (q.size() == 0) begin
                    chk("model_has_word", 64'(q.size()), 64'd1);
                end else begin
                    chk("tdata", 64'(tdata), 64'(q[0].d));
                    chk("tlast", 64'(tlast), 64'(q[0].last));
                end
            end else begin
                chk("tlast_idle", 64'(tlast), 64'd0);
            end
            if (stall_prev) begin
                chk("stall_tvalid", 64'(tvalid), 64'd1);
                chk("stall_tdata", 64'(tdata), 64'(prev_data));
            end
            // Effects of the coming rising edge
            acc    = in_w_e && (m_cnt != DEPTH);
            m_done = 1'b0;
            if (tvalid && tready && q.size() > 0) begin
                e = q.pop_front();
                hs_total++;
                if (e.last) m_done = 1'b1;
                if (e.eob)  m_cnt--;
            end
            if (in_w_e && !acc) m_ovf = 1'b1;
            if (acc) begin
                m_cnt++;
                push_blk(in_data, in_last);
            end
            stall_prev = tvalid && !tready;
            prev_data  = tdata;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (all called at posedge + 1)
    // ------------------------------------------------------------------
    task automatic wr(input logic [127:0] d, input logic l);
        in_w_e  = 1'b1;
        in_data = d;
        in_last = l;
        @(posedge clk); #1;
        in_w_e  = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int maxc);
        int n = 0;
        while ((tvalid || in_blk_cnt != 0) && n < maxc) begin
            @(posedge clk); #1;
            n++;
        end
        chk(name, 64'(tvalid || in_blk_cnt != 0), 64'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    logic [127:0] blk0 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    logic [127:0] blks [3];
    logic [31:0]  lit0 [4];

    task automatic single_check(input string tag);
        tready = 1'b1;
        wr(blk0, 1'b1);
        chk({tag, "_tvalid_n0"}, 64'(tvalid), 64'd0);
        @(posedge clk); #1;
        chk({tag, "_tvalid_n1"}, 64'(tvalid), 64'd0);
        @(posedge clk); #1;
        chk({tag, "_tvalid_n2"}, 64'(tvalid), 64'd1);
        for (int k = 0; k < 4; k++) begin
            chk({tag, "_word"}, 64'(tdata), 64'(sw(lit0[k])));
            chk({tag, "_tlast"}, 64'(tlast), 64'(k == 3));
`ifdef AES_OUT_BYTESWAP_EN
            if (k == 0) chk({tag, "_bswap_w0"}, 64'(tdata), 64'h33221100);
`endif
            @(posedge clk); #1;
        end
        chk({tag, "_tvalid_end"}, 64'(tvalid), 64'd0);
        chk({tag, "_tx_done"}, 64'(tx_done), 64'd1);
        chk({tag, "_cnt_end"}, 64'(in_blk_cnt), 64'd0);
        @(posedge clk); #1;
        chk({tag, "_tx_done_off"}, 64'(tx_done), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int tl;
        int base;
        logic [31:0] got [12];
        logic        gl  [12];
        logic [3:0]  pat;

        lit0[0] = 32'h00112233; lit0[1] = 32'h44556677;
        lit0[2] = 32'h8899AABB; lit0[3] = 32'hCCDDEEFF;
        blks[0] = 128'h01010101_02020202_03030303_04040404;
        blks[1] = 128'hA0A1A2A3_B0B1B2B3_C0C1C2C3_D0D1D2D3;
        blks[2] = 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0;
        pat     = 4'b1001;

        // Reset values
        #1 reset = 1'b1;
        #1;
        chk("rst_tvalid", 64'(tvalid), 64'd0);
        chk("rst_tlast", 64'(tlast), 64'd0);
        chk("rst_tx_done", 64'(tx_done), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_in_full", 64'(in_full), 64'd0);
        chk("rst_cnt", 64'(in_blk_cnt), 64'd0);
        chk("rst_tdata", 64'(tdata), 64'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;

        // Single block: latency, word order, tlast, tx_done
        single_check("s1");

        // Back-to-back three blocks, no gaps
        tready = 1'b1;
        wr(blks[0], 1'b0);
        wr(blks[1], 1'b0);
        wr(blks[2], 1'b1);
        n = 0;
        while (!tvalid && n < 20) begin @(posedge clk); #1; n++; end
        for (int i = 0; i < 12; i++) begin
            chk("b2b_nogap", 64'(tvalid), 64'd1);
            chk("b2b_word", 64'(tdata), 64'(sw(blks[i/4][127-32*(i%4) -: 32])));
            chk("b2b_tlast", 64'(tlast), 64'(i == 11));
            @(posedge clk); #1;
        end
        chk("b2b_tvalid_end", 64'(tvalid), 64'd0);
        wait_idle("b2b_idle", 50);

        // Backpressure: tready 1,0,0,1 repeating
        tready = 1'b0;
        wr(blks[0], 1'b0);
        wr(blks[1], 1'b0);
        wr(blks[2], 1'b1);
        n = 0;
        for (int c = 0; c < 200 && n < 12; c++) begin
            tready = pat[3 - (c % 4)];
            if (tvalid && tready) begin
                got[n] = tdata;
                gl[n]  = tlast;
                n++;
            end
            @(posedge clk); #1;
        end
        chk("bp_count", 64'(n), 64'd12);
        tl = 0;
        for (int i = 0; i < 12; i++) begin
            chk("bp_word", 64'(got[i]), 64'(sw(blks[i/4][127-32*(i%4) -: 32])));
            if (gl[i]) tl++;
        end
        chk("bp_tlast_count", 64'(tl), 64'd1);
        chk("bp_tlast_pos", 64'(gl[11]), 64'd1);
        tready = 1'b1;
        wait_idle("bp_idle", 50);

        // Full / overflow / wrap
        tready = 1'b0;
        for (int i = 0; i < 512; i++) begin
            wr({i[31:0], ~i[31:0], i[31:0] ^ 32'hA5A5A5A5, 32'h1000 + i[31:0]}, (i % 64) == 63);
            if (i == 510) chk("full_at_511", 64'(in_full), 64'd0);
        end
        chk("full_at_512", 64'(in_full), 64'd1);
        chk("cnt_at_512", 64'(in_blk_cnt), 64'd512);
        chk("ovf_before", 64'(overflow), 64'd0);
        wr(128'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_0000, 1'b1);
        chk("ovf_after", 64'(overflow), 64'd1);
        chk("cnt_after_drop", 64'(in_blk_cnt), 64'd512);
        tready = 1'b1;
        wait_idle("full_drain", 3000);
        chk("ovf_sticky", 64'(overflow), 64'd1);

        // Simultaneous write and word-3 handshake
        tready = 1'b1;
        wr(blks[1], 1'b1);
        n = 0;
        while (!tlast && n < 20) begin @(posedge clk); #1; n++; end
        chk("sim_cnt_before", 64'(in_blk_cnt), 64'd1);
        in_w_e  = 1'b1;
        in_data = blks[2];
        in_last = 1'b1;
        @(posedge clk); #1;
        in_w_e  = 1'b0;
        in_last = 1'b0;
        chk("sim_cnt_after", 64'(in_blk_cnt), 64'd1);
        chk("sim_tx_done", 64'(tx_done), 64'd1);
        wait_idle("sim_idle", 50);

        // Reset during word 1 of block 2
        tready = 1'b1;
        base = hs_total;
        wr(blks[0], 1'b0);
        wr(blks[1], 1'b0);
        wr(blks[2], 1'b1);
        n = 0;
        while (hs_total < base + 5 && n < 50) begin @(posedge clk); #1; n++; end
        chk("rst_mid_word", 64'(tdata), 64'(sw(blks[1][95:64])));
        reset = 1'b1;
        #1;
        chk("rst_mid_tvalid", 64'(tvalid), 64'd0);
        chk("rst_mid_cnt", 64'(in_blk_cnt), 64'd0);
        chk("rst_mid_ovf", 64'(overflow), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        single_check("post_rst");

        // Randomized traffic
        for (int c = 0; c < 600; c++) begin
            in_w_e  = ($urandom_range(0, 9) < 4);
            in_data = {$urandom, $urandom, $urandom, $urandom};
            in_last = ($urandom_range(0, 3) == 0);
            tready  = ($urandom_range(0, 9) < 7);
            @(posedge clk); #1;
        end
        in_w_e  = 1'b0;
        in_last = 1'b0;
        tready  = 1'b1;
        wait_idle("rand_drain", 3000);
        chk("model_drained", 64'(q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
